// File: rtl/adc_sample_controller.sv
// Sequencer for a 16-bit serial SAR ADC: CNV pulse, conversion wait, 16 SCK periods,
// then the parallel result with a one-cycle valid strobe. Triggered by a sample timer or single shot.
module adc_sample_controller #(
  parameter int unsigned SAMPLE_PERIOD    = 100,
  parameter int unsigned CNV_HIGH_CYCLES  = 4,
  parameter int unsigned CONV_WAIT_CYCLES = 8,
  parameter int unsigned SCK_HALF_CYCLES  = 2
) (
  input  logic        clk_p,
  input  logic        reset_p,
  input  logic        enable_p,
  input  logic        start_p,
  input  logic        overrun_clr_p,
  input  logic        sdo_p,
  output logic        cnv_p,
  output logic        sck_p,
  output logic [15:0] data_p,
  output logic        data_valid_p,
  output logic        busy_p,
  output logic        overrun_p
);

  localparam int unsigned DATA_W   = 16;
  localparam int unsigned CNT_W    = 5;
  localparam int unsigned TMR_W    = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam int unsigned PH_MAX_A = (CNV_HIGH_CYCLES > CONV_WAIT_CYCLES) ? CNV_HIGH_CYCLES
                                                                          : CONV_WAIT_CYCLES;
  localparam int unsigned PH_MAX   = (PH_MAX_A > SCK_HALF_CYCLES) ? PH_MAX_A : SCK_HALF_CYCLES;
  localparam int unsigned PH_W     = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CNV    = 3'd1;
  localparam logic [2:0] S_WAIT   = 3'd2;
  localparam logic [2:0] S_SCK_LO = 3'd3;
  localparam logic [2:0] S_SCK_HI = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  logic [2:0]        r_state;
  logic [2:0]        w_state_nxt;
  logic [TMR_W-1:0]  r_timer;
  logic [PH_W-1:0]   r_phase;
  logic [PH_W-1:0]   w_ph_last_val;
  logic [CNT_W-1:0]  r_bit_cnt;
  logic [DATA_W-1:0] r_shift;
  logic              w_tick;
  logic              w_trigger;
  logic              w_ph_last;
  logic              w_shift;
  logic              w_bits_done;

  assign w_tick      = enable_p && (r_timer == TMR_W'(SAMPLE_PERIOD - 1));
  assign w_trigger   = w_tick || start_p;
  assign w_ph_last   = (r_phase == w_ph_last_val);
  // First cycle of SCK_HI is the edge that raises sck_p, i.e. the ADC data sample point
  assign w_shift     = (r_state == S_SCK_HI) && (r_phase == '0);
  assign w_bits_done = (r_bit_cnt == CNT_W'(DATA_W)) ||
                       (w_shift && (r_bit_cnt == CNT_W'(DATA_W - 1)));

  // Sample-rate timer, held at zero while disabled
  always_ff @(posedge clk_p or posedge reset_p) begin
    if (reset_p) begin
      r_timer <= '0;
    end else if (!enable_p || w_tick) begin
      r_timer <= '0;
    end else begin
      r_timer <= r_timer + TMR_W'(1);
    end
  end

  // Last phase-count value of the current timed state
  always_comb begin
    w_ph_last_val = '0;
    case (r_state)
      S_CNV:              w_ph_last_val = PH_W'(CNV_HIGH_CYCLES - 1);
      S_WAIT:             w_ph_last_val = PH_W'(CONV_WAIT_CYCLES - 1);
      S_SCK_LO, S_SCK_HI: w_ph_last_val = PH_W'(SCK_HALF_CYCLES - 1);
      default:            ;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_trigger) w_state_nxt = S_CNV;
      S_CNV:    if (w_ph_last) w_state_nxt = S_WAIT;
      S_WAIT:   if (w_ph_last) w_state_nxt = S_SCK_LO;
      S_SCK_LO: if (w_ph_last) w_state_nxt = S_SCK_HI;
      S_SCK_HI: if (w_ph_last) w_state_nxt = w_bits_done ? S_DONE : S_SCK_LO;
      S_DONE:   w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_p or posedge reset_p) begin
    if (reset_p) begin
      r_state <= S_IDLE;
      r_phase <= '0;
    end else begin
      r_state <= w_state_nxt;
      if ((w_state_nxt != r_state) || (r_state == S_IDLE)) begin
        r_phase <= '0;
      end else begin
        r_phase <= r_phase + PH_W'(1);
      end
    end
  end

  always_ff @(posedge clk_p or posedge reset_p) begin
    if (reset_p) begin
      r_bit_cnt <= '0;
      r_shift   <= '0;
    end else if (r_state == S_DONE) begin
      r_bit_cnt <= '0;
    end else if (w_shift) begin
      r_bit_cnt <= r_bit_cnt + CNT_W'(1);
      r_shift   <= {r_shift[DATA_W-2:0], sdo_p};
    end
  end

  // Pin and status outputs registered from the current state
  always_ff @(posedge clk_p or posedge reset_p) begin
    if (reset_p) begin
      cnv_p        <= 1'b0;
      sck_p        <= 1'b1;
      data_p       <= '0;
      data_valid_p <= 1'b0;
      busy_p       <= 1'b0;
      overrun_p    <= 1'b0;
    end else begin
      cnv_p        <= (r_state == S_CNV);
      sck_p        <= (r_state != S_SCK_LO);
      busy_p       <= (r_state != S_IDLE) && (r_state != S_DONE);
      data_valid_p <= (r_state == S_DONE);
      if (r_state == S_DONE) begin
        data_p <= r_shift;
      end
      if (w_tick && (r_state != S_IDLE)) begin
        overrun_p <= 1'b1;
      end else if (overrun_clr_p) begin
        overrun_p <= 1'b0;
      end
    end
  end

endmodule
